// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default datapath width
// and fetch FSM state encodings.
package instr_fetch_pkg;

    localparam int unsigned IF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } if_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory read at a time, captures the
// response and holds it for decode, discarding responses made stale by a flush.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_pc_counter_en,
    input  logic                  i_flush,
    output logic                  o_mem_rd_en,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_inst_valid,
    output logic [DATA_WIDTH-1:0] o_inst,
    input  logic                  i_inst_ready,
    output logic                  o_protocol_err
);

    if_state_e             state_q, state_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  err_q, err_d;
    logic                  rd_en;
    logic                  cnt_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            drop_q  <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (drop_q) begin
                    // Waiting out the response to a flushed request; no new strobe yet.
                    if (i_mem_rd_valid) drop_d = 1'b0;
                end else begin
                    rd_en = 1'b1;
                    if (i_mem_rd_valid) err_d = 1'b1;
                    if (i_flush) drop_d  = 1'b1;
                    else         state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_flush) begin
                    state_d = FETCH;
                    if (!i_mem_rd_valid) drop_d = 1'b1;
                end else if (i_mem_rd_valid) begin
                    inst_d  = i_mem_rd_data;
                    cnt_en  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_mem_rd_valid) err_d = 1'b1;
                if (i_flush || i_inst_ready) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign o_mem_rd_en     = rd_en && !rst;
    assign o_pc_counter_en = cnt_en && !rst;
    assign o_mem_addr      = o_mem_rd_en ? i_pc : '0;
    assign o_inst_valid    = (state_q == HOLD);
    assign o_inst          = inst_q;
    assign o_protocol_err  = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hand-computed expectations for normal fetch,
// backpressure, flush cases, protocol errors and reset behaviour.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_pc = '0;
    logic       o_pc_counter_en;
    logic       i_flush = 1'b0;
    logic       o_mem_rd_en;
    logic [7:0] o_mem_addr;
    logic       i_mem_rd_valid = 1'b0;
    logic [7:0] i_mem_rd_data = '0;
    logic       o_inst_valid;
    logic [7:0] o_inst;
    logic       i_inst_ready = 1'b0;
    logic       o_protocol_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_pc            (i_pc),
        .o_pc_counter_en (o_pc_counter_en),
        .i_flush         (i_flush),
        .o_mem_rd_en     (o_mem_rd_en),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rd_valid  (i_mem_rd_valid),
        .i_mem_rd_data   (i_mem_rd_data),
        .o_inst_valid    (o_inst_valid),
        .o_inst          (o_inst),
        .i_inst_ready    (i_inst_ready),
        .o_protocol_err  (o_protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after the falling edge; outputs are then sampled mid-cycle.
    task automatic drive(input logic r, input logic fl, input logic [7:0] pc,
                         input logic v, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        rst            = r;
        i_flush        = fl;
        i_pc           = pc;
        i_mem_rd_valid = v;
        i_mem_rd_data  = d;
        i_inst_ready   = rdy;
        #1;
    endtask

    initial begin
        // Reset
        drive(1, 0, 8'h00, 0, 8'h00, 0);
        check("rst_rd_en", 32'(o_mem_rd_en), 0);
        check("rst_cnt_en", 32'(o_pc_counter_en), 0);
        drive(1, 1, 8'h00, 1, 8'h11, 0);
        check("rst_valid", 32'(o_inst_valid), 0);
        check("rst_inst", 32'(o_inst), 0);
        check("rst_err", 32'(o_protocol_err), 0);
        check("rst_ovr_rd_en", 32'(o_mem_rd_en), 0);

        // Basic fetch
        drive(0, 0, 8'h10, 0, 8'h00, 1);
        check("b_rd_en", 32'(o_mem_rd_en), 1);
        check("b_addr", 32'(o_mem_addr), 32'h10);
        check("b_valid0", 32'(o_inst_valid), 0);
        check("b_cnt0", 32'(o_pc_counter_en), 0);
        drive(0, 0, 8'h10, 1, 8'hA5, 1);
        check("b_cnt_en", 32'(o_pc_counter_en), 1);
        check("b_rd_en_wait", 32'(o_mem_rd_en), 0);
        check("b_addr_idle", 32'(o_mem_addr), 0);
        drive(0, 0, 8'h11, 0, 8'h00, 1);
        check("b_valid", 32'(o_inst_valid), 1);
        check("b_inst", 32'(o_inst), 32'hA5);
        check("b_cnt_hold", 32'(o_pc_counter_en), 0);

        // Backpressure
        drive(0, 0, 8'h11, 0, 8'h00, 0);
        check("bp_valid_drop", 32'(o_inst_valid), 0);
        check("bp_rd_en", 32'(o_mem_rd_en), 1);
        check("bp_addr", 32'(o_mem_addr), 32'h11);
        drive(0, 0, 8'h11, 1, 8'hA5, 0);
        check("bp_cnt_en", 32'(o_pc_counter_en), 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 8'h12, 0, 8'h00, 0);
            check("bp_hold_valid", 32'(o_inst_valid), 1);
            check("bp_hold_inst", 32'(o_inst), 32'hA5);
            check("bp_hold_rd_en", 32'(o_mem_rd_en), 0);
        end
        drive(0, 0, 8'h12, 0, 8'h00, 1);
        check("bp_release_valid", 32'(o_inst_valid), 1);

        // Flush in WAIT, stale response three cycles later
        drive(0, 0, 8'h12, 0, 8'h00, 0);
        check("fw_rd_en", 32'(o_mem_rd_en), 1);
        check("fw_addr", 32'(o_mem_addr), 32'h12);
        drive(0, 1, 8'h40, 0, 8'h00, 0);
        check("fw_flush_cnt", 32'(o_pc_counter_en), 0);
        drive(0, 0, 8'h40, 0, 8'h00, 0);
        check("fw_drop_rd_en1", 32'(o_mem_rd_en), 0);
        check("fw_drop_addr", 32'(o_mem_addr), 0);
        drive(0, 0, 8'h40, 0, 8'h00, 0);
        check("fw_drop_rd_en2", 32'(o_mem_rd_en), 0);
        drive(0, 0, 8'h40, 1, 8'h33, 0);
        check("fw_stale_rd_en", 32'(o_mem_rd_en), 0);
        check("fw_stale_cnt", 32'(o_pc_counter_en), 0);
        drive(0, 0, 8'h40, 0, 8'h00, 0);
        check("fw_target_rd_en", 32'(o_mem_rd_en), 1);
        check("fw_target_addr", 32'(o_mem_addr), 32'h40);
        check("fw_no_err", 32'(o_protocol_err), 0);
        check("fw_inst_kept", 32'(o_inst), 32'hA5);
        check("fw_valid", 32'(o_inst_valid), 0);

        // Flush and response together in WAIT
        drive(0, 1, 8'h50, 1, 8'h77, 0);
        check("fv_cnt", 32'(o_pc_counter_en), 0);
        drive(0, 0, 8'h50, 0, 8'h00, 0);
        check("fv_valid", 32'(o_inst_valid), 0);
        check("fv_rd_en", 32'(o_mem_rd_en), 1);
        check("fv_addr", 32'(o_mem_addr), 32'h50);
        check("fv_inst", 32'(o_inst), 32'hA5);
        drive(0, 0, 8'h50, 1, 8'h99, 0);
        check("fv_cnt_en", 32'(o_pc_counter_en), 1);

        // Spurious response in HOLD
        drive(0, 0, 8'h51, 1, 8'hEE, 0);
        check("sp_valid", 32'(o_inst_valid), 1);
        check("sp_err_before", 32'(o_protocol_err), 0);
        drive(0, 0, 8'h51, 0, 8'h00, 0);
        check("sp_err", 32'(o_protocol_err), 1);
        check("sp_inst", 32'(o_inst), 32'h99);
        check("sp_valid_kept", 32'(o_inst_valid), 1);

        // Flush beats ready in HOLD; flush while issuing sets drop
        drive(0, 1, 8'h60, 0, 8'h00, 1);
        check("fh_cnt", 32'(o_pc_counter_en), 0);
        drive(0, 1, 8'h60, 0, 8'h00, 0);
        check("fh_valid", 32'(o_inst_valid), 0);
        check("ff_rd_en", 32'(o_mem_rd_en), 1);
        check("ff_addr", 32'(o_mem_addr), 32'h60);
        check("ff_err_sticky", 32'(o_protocol_err), 1);
        drive(0, 0, 8'h60, 0, 8'h00, 0);
        check("ff_drop_rd_en", 32'(o_mem_rd_en), 0);
        drive(0, 0, 8'h60, 1, 8'h12, 0);
        check("ff_stale_rd_en", 32'(o_mem_rd_en), 0);
        drive(0, 0, 8'h60, 0, 8'h00, 0);
        check("ff_reissue", 32'(o_mem_rd_en), 1);
        drive(0, 0, 8'h60, 1, 8'h24, 0);
        check("ff_cnt_en", 32'(o_pc_counter_en), 1);

        // Reset in HOLD
        drive(1, 0, 8'h60, 0, 8'h00, 0);
        check("rh_rd_en", 32'(o_mem_rd_en), 0);
        check("rh_valid_pre", 32'(o_inst_valid), 1);
        drive(0, 0, 8'h60, 0, 8'h00, 0);
        check("rh_valid", 32'(o_inst_valid), 0);
        check("rh_inst", 32'(o_inst), 0);
        check("rh_err", 32'(o_protocol_err), 0);
        check("rh_rd_en_after", 32'(o_mem_rd_en), 1);
        check("rh_addr", 32'(o_mem_addr), 32'h60);

        // Response to a pre-reset request is unexpected
        drive(1, 0, 8'h60, 0, 8'h00, 0);
        drive(0, 0, 8'h70, 1, 8'h55, 0);
        check("lr_rd_en", 32'(o_mem_rd_en), 1);
        check("lr_addr", 32'(o_mem_addr), 32'h70);
        check("lr_cnt", 32'(o_pc_counter_en), 0);
        drive(0, 0, 8'h70, 0, 8'h00, 0);
        check("lr_err", 32'(o_protocol_err), 1);
        check("lr_valid", 32'(o_inst_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
